// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Front end of the pipeline. Keeps a fetch PC, reads a combinational
//   instruction memory and queues {pc, instr} pairs in a small FIFO that the
//   decode stage drains with a valid/ready handshake. A redirect flushes
//   everything except an instruction being accepted in the same cycle and
//   restarts fetching at the new target.
//
//   Optional feature (macro IFETCH_MISALIGN_CHECK_EN):
//     defined   -> a redirect to a non-word-aligned target enters FAULT,
//                  raises fetch_fault and stops fetching until an aligned
//                  redirect (or rst) arrives.
//     undefined -> the low two target bits are dropped, FAULT is never
//                  entered and fetch_fault is constant 0.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  fetch buffer entries (power of two, 2..8)
//
// Ports
//   clk              clock, all state changes on the rising edge
//   rst              synchronous active-high reset
//   imem_addr        fetch address to instruction memory
//   imem_rdata       instruction word for imem_addr (same cycle)
//   redirect_valid   branch/jump redirect request
//   redirect_target  new fetch address
//   if_valid         buffer head holds a valid instruction
//   if_ready         decode accepts the head this cycle
//   if_instr         instruction at the buffer head
//   if_pc            address of if_instr
//   fetch_fault      misaligned-redirect fault flag
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_fault
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  typedef enum logic {
    RUN,
    FAULT
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PTR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]  rd_ptr_q, rd_ptr_d;

  logic [31:0]     pc_mem    [FIFO_DEPTH];
  logic [31:0]     instr_mem [FIFO_DEPTH];

  logic            fifo_empty;
  logic            fifo_full;
  logic            transfer;
  logic            do_write;
  logic [31:0]     target;
  logic            target_misaligned;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign target            = redirect_target;
  assign target_misaligned = (redirect_target[1:0] != 2'b00);
  assign fetch_fault       = (state_q == FAULT);
`else
  // Low bits are simply dropped, so a misaligned target can never fault.
  assign target            = redirect_target & 32'hFFFF_FFFC;
  assign target_misaligned = 1'b0;
  assign fetch_fault       = 1'b0;
`endif

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bits means full.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign if_valid  = !fifo_empty;
  assign if_pc     = pc_mem[rd_ptr_q[PTR_W-1:0]];
  assign if_instr  = instr_mem[rd_ptr_q[PTR_W-1:0]];
  assign transfer  = if_valid && if_ready;
  assign imem_addr = fetch_pc_q;

  // Next-state logic. A redirect wins over fetching: the accepted head (if
  // any) has already left through the handshake, so resetting both
  // pointers drops only the entries that were still waiting.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    do_write   = 1'b0;

    if (redirect_valid) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = target;
      state_d    = target_misaligned ? FAULT : RUN;
    end else begin
      if (transfer) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      // A full buffer can still take a word when the head leaves this cycle.
      if ((state_q == RUN) && (!fifo_full || transfer)) begin
        do_write   = 1'b1;
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Buffer storage needs no reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_write && !rst) begin
      pc_mem[wr_ptr_q[PTR_W-1:0]]    <= fetch_pc_q;
      instr_mem[wr_ptr_q[PTR_W-1:0]] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//   Self-checking bench for instruction_fetch (RESET_PC = 0, FIFO_DEPTH = 2).
//   Instruction memory is modelled as word(addr) = (addr >> 2) ^ salt.
//   Directed scenarios cover reset, streaming, stall, redirect, address
//   wrap, misaligned redirect and reset with a full buffer; a random phase
//   compares every presented head against an in-order PC model.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;

  logic [31:0] salt = 32'h0;
  int          passCnt = 0;
  int          totalCnt = 0;

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory.
  assign imem_rdata = (imem_addr >> 2) ^ salt;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a >> 2) ^ salt;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1 unit later, well away from either edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    if_ready = 1'b0;
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  // Reset state, then a stream of word n = n from address 0.
  task automatic test_reset();
    salt = 32'h0;
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    if_ready = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
    redirect_valid = 1'b0;
    #1;
    totalCnt++; if (if_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", if_valid); else passCnt++;
    totalCnt++; if (imem_addr !== 32'h0) $display("[TB] FAIL reset_addr: got %h want 0", imem_addr); else passCnt++;
    totalCnt++; if (fetch_fault !== 1'b0) $display("[TB] FAIL reset_fault: got %b want 0", fetch_fault); else passCnt++;
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      #1;
      totalCnt++; if (if_valid !== 1'b1) $display("[TB] FAIL stream_valid[%0d]: got %b want 1", k, if_valid); else passCnt++;
      totalCnt++; if (if_pc !== 32'(4 * k)) $display("[TB] FAIL stream_pc[%0d]: got %h want %h", k, if_pc, 32'(4 * k)); else passCnt++;
      totalCnt++; if (if_instr !== 32'(k)) $display("[TB] FAIL stream_instr[%0d]: got %h want %h", k, if_instr, 32'(k)); else passCnt++;
    end
  endtask

  // Five stalled cycles fill the buffer with pc 0,4; release drains in order.
  task automatic test_stall();
    doReset();
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c >= 2) begin
        totalCnt++; if (if_pc !== 32'h0) $display("[TB] FAIL stall_pc[%0d]: got %h want 0", c, if_pc); else passCnt++;
        totalCnt++; if (imem_addr !== 32'h8) $display("[TB] FAIL stall_addr[%0d]: got %h want 8", c, imem_addr); else passCnt++;
      end
      nextCycle();
    end
    if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      // Redirect while the pc 8 head is being accepted.
      if (k == 2) begin
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
      end
      #1;
      totalCnt++; if (if_valid !== 1'b1) $display("[TB] FAIL release_valid[%0d]: got %b want 1", k, if_valid); else passCnt++;
      totalCnt++; if (if_pc !== 32'(4 * k)) $display("[TB] FAIL release_pc[%0d]: got %h want %h", k, if_pc, 32'(4 * k)); else passCnt++;
      nextCycle();
    end
  endtask

  // Continues from test_stall: the cycle after the redirect is empty.
  task automatic test_redirect();
    redirect_valid = 1'b0;
    #1;
    totalCnt++; if (if_valid !== 1'b0) $display("[TB] FAIL redir_gap: got %b want 0", if_valid); else passCnt++;
    totalCnt++; if (imem_addr !== 32'h100) $display("[TB] FAIL redir_addr: got %h want 100", imem_addr); else passCnt++;
    nextCycle();
    #1;
    totalCnt++; if (if_valid !== 1'b1) $display("[TB] FAIL redir_valid: got %b want 1", if_valid); else passCnt++;
    totalCnt++; if (if_pc !== 32'h100) $display("[TB] FAIL redir_pc: got %h want 100", if_pc); else passCnt++;
    totalCnt++; if (if_instr !== memWord(32'h100)) $display("[TB] FAIL redir_instr: got %h want %h", if_instr, memWord(32'h100)); else passCnt++;
  endtask

  task automatic test_wrap();
    logic [31:0] expPc;
    nextCycle();
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFF8;
    nextCycle();
    redirect_valid = 1'b0;
    #1;
    totalCnt++; if (if_valid !== 1'b0) $display("[TB] FAIL wrap_gap: got %b want 0", if_valid); else passCnt++;
    expPc = 32'hFFFF_FFF8;
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      #1;
      totalCnt++; if (if_pc !== expPc) $display("[TB] FAIL wrap_pc[%0d]: got %h want %h", k, if_pc, expPc); else passCnt++;
      totalCnt++; if (if_instr !== memWord(expPc)) $display("[TB] FAIL wrap_instr[%0d]: got %h want %h", k, if_instr, memWord(expPc)); else passCnt++;
      expPc = expPc + 32'd4;
    end
  endtask

  task automatic test_misalign();
    nextCycle();
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h102;
    nextCycle();
    redirect_valid = 1'b0;
    #1;
`ifdef IFETCH_MISALIGN_CHECK_EN
    totalCnt++; if (fetch_fault !== 1'b1) $display("[TB] FAIL fault_set: got %b want 1", fetch_fault); else passCnt++;
    totalCnt++; if (if_valid !== 1'b0) $display("[TB] FAIL fault_valid: got %b want 0", if_valid); else passCnt++;
    nextCycle();
    #1;
    totalCnt++; if (if_valid !== 1'b0) $display("[TB] FAIL fault_nofetch: got %b want 0", if_valid); else passCnt++;
    totalCnt++; if (imem_addr !== 32'h102) $display("[TB] FAIL fault_addr: got %h want 102", imem_addr); else passCnt++;
    totalCnt++; if (fetch_fault !== 1'b1) $display("[TB] FAIL fault_hold: got %b want 1", fetch_fault); else passCnt++;
    redirect_valid = 1'b1;
    redirect_target = 32'h200;
    nextCycle();
    redirect_valid = 1'b0;
    #1;
    totalCnt++; if (fetch_fault !== 1'b0) $display("[TB] FAIL fault_clear: got %b want 0", fetch_fault); else passCnt++;
    totalCnt++; if (if_valid !== 1'b0) $display("[TB] FAIL fault_gap: got %b want 0", if_valid); else passCnt++;
    nextCycle();
    #1;
    totalCnt++; if (if_pc !== 32'h200) $display("[TB] FAIL fault_resume_pc: got %h want 200", if_pc); else passCnt++;
`else
    totalCnt++; if (fetch_fault !== 1'b0) $display("[TB] FAIL nofault_flag: got %b want 0", fetch_fault); else passCnt++;
    totalCnt++; if (if_valid !== 1'b0) $display("[TB] FAIL nofault_gap: got %b want 0", if_valid); else passCnt++;
    nextCycle();
    #1;
    totalCnt++; if (if_valid !== 1'b1) $display("[TB] FAIL nofault_valid: got %b want 1", if_valid); else passCnt++;
    totalCnt++; if (if_pc !== 32'h100) $display("[TB] FAIL nofault_pc: got %h want 100", if_pc); else passCnt++;
    totalCnt++; if (fetch_fault !== 1'b0) $display("[TB] FAIL nofault_flag2: got %b want 0", fetch_fault); else passCnt++;
`endif
  endtask

  // Reset must win over a redirect and a handshake with a full buffer.
  task automatic test_reset_full();
    nextCycle();
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    nextCycle();
    nextCycle();
    nextCycle();
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h300;
    if_ready = 1'b1;
    nextCycle();
    rst = 1'b0;
    redirect_valid = 1'b0;
    #1;
    totalCnt++; if (if_valid !== 1'b0) $display("[TB] FAIL rstfull_valid: got %b want 0", if_valid); else passCnt++;
    totalCnt++; if (imem_addr !== 32'h0) $display("[TB] FAIL rstfull_addr: got %h want 0", imem_addr); else passCnt++;
    totalCnt++; if (fetch_fault !== 1'b0) $display("[TB] FAIL rstfull_fault: got %b want 0", fetch_fault); else passCnt++;
    nextCycle();
    #1;
    totalCnt++; if (if_pc !== 32'h0) $display("[TB] FAIL rstfull_first_pc: got %h want 0", if_pc); else passCnt++;
  endtask

  // Random handshake and redirects. The model is just "the next instruction
  // decode should see" plus the number of cycles since the last flush: the
  // buffer is empty for exactly one cycle after a flush and never runs dry
  // afterwards, because a word is fetched every cycle unless it is full.
  task automatic test_random();
    logic [31:0] expPc;
    logic [31:0] tgt;
    logic        rdy;
    logic        redir;
    int          age;
    salt = $urandom();
    doReset();
    expPc = 32'h0;
    age = 0;
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      tgt = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hC);
      if_ready = rdy;
      redirect_valid = redir;
      redirect_target = tgt;
      #1;
      totalCnt++; if (if_valid !== (age != 0)) $display("[TB] FAIL rnd_valid[%0d]: got %b want %b", c, if_valid, (age != 0)); else passCnt++;
      if (age != 0) begin
        totalCnt++; if (if_pc !== expPc) $display("[TB] FAIL rnd_pc[%0d]: got %h want %h", c, if_pc, expPc); else passCnt++;
        totalCnt++; if (if_instr !== memWord(expPc)) $display("[TB] FAIL rnd_instr[%0d]: got %h want %h", c, if_instr, memWord(expPc)); else passCnt++;
      end
      nextCycle();
      if (age != 0 && rdy) expPc = expPc + 32'd4;
      if (redir) begin
        expPc = tgt;
        age = 0;
      end else if (age < 2) begin
        age++;
      end
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    if_ready = 1'b0;
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
    test_misalign();
    test_reset_full();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2 (legal 2..8, power of two): fetch buffer entries.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port imem_addr  output  32  fetch address to the combinational instruction memory.
REQ-006 SHALL have port imem_rdata  input  32  instruction word returned the same cycle for imem_addr.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_target  input  32  new fetch address, sampled when redirect_valid=1.
REQ-009 SHALL have port if_valid  output  1  buffer head holds a valid instruction.
REQ-010 SHALL have port if_ready  input  1  decode accepts the head; transfer when if_valid and if_ready are both 1.
REQ-011 SHALL have port if_instr  output  32  instruction at the buffer head.
REQ-012 SHALL have port if_pc  output  32  address of if_instr.
REQ-013 SHALL have port fetch_fault  output  1  misaligned-redirect fault flag (REQ-030).

Function
REQ-014 SHALL hold fetch_pc and drive imem_addr = fetch_pc combinationally.
REQ-015 SHALL implement a FIFO_DEPTH-entry FIFO of {pc, instr} with read/write pointers one bit wider than log2(FIFO_DEPTH) for full/empty.
REQ-016 SHALL use FSM states RUN and FAULT; RUN after reset.
REQ-017 In RUN with no redirect, SHALL write {fetch_pc, imem_rdata} and set fetch_pc = fetch_pc + 4 when FIFO not full, or full with a transfer this cycle.
REQ-018 SHALL not write or advance fetch_pc when FIFO full and no transfer occurs.
REQ-019 SHALL drive if_valid = FIFO not empty; if_instr/if_pc from head; pop on transfer.
REQ-020 Latency: instruction fetched at edge N SHALL be presented on if_valid/if_instr in the cycle after edge N (one cycle).
REQ-021 Sustained throughput SHALL be one instruction per cycle while if_ready=1.
REQ-022 fetch_pc addition SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-023 On redirect_valid=1: a transfer in that cycle SHALL complete; all other entries SHALL be flushed; no FIFO write that cycle; fetch_pc = redirect_target.
REQ-024 if_valid SHALL be 0 in the cycle after a redirect; target instruction SHALL appear one cycle later.
REQ-025 Back-to-back redirects SHALL each take effect; the last one sets fetch_pc.
REQ-026 if_instr/if_pc SHALL remain stable while if_valid=1 and if_ready=0 (absent redirect).

Reset
REQ-027 rst=1 at an edge SHALL set fetch_pc=RESET_PC, empty FIFO, state RUN, fetch_fault=0; if_valid=0 the following cycle.
REQ-028 rst SHALL override redirect_valid and if_ready in the same cycle; reset mid-stream SHALL discard all buffered entries.
REQ-029 The first fetch (of RESET_PC) SHALL occur at the first edge with rst=0.

Configuration
REQ-030 With macro IFETCH_MISALIGN_CHECK_EN defined: redirect with redirect_target[1:0]!=0 SHALL flush, enter FAULT, set fetch_fault=1, set fetch_pc=target; FAULT SHALL not fetch (if_valid=0); a later aligned redirect SHALL return to RUN and clear fetch_fault; only rst also clears it.
REQ-031 Without IFETCH_MISALIGN_CHECK_EN: redirect_target[1:0] SHALL be forced to 2'b00, FAULT SHALL be unreachable, fetch_fault tied 0.

Verification
REQ-032 Reset, RESET_PC=0, memory word n = n, if_ready=1 -> if_pc 0,4,8,12 with if_instr 0,1,2,3 on consecutive cycles, starting one cycle after rst falls.
REQ-033 if_ready=0 for 5 cycles -> FIFO holds 2 entries (pc 0,4), imem_addr stays 8, if_pc stable at 0; release -> 0,4,8 in order, no gap or duplicate.
REQ-034 redirect_valid=1, target 32'h100, while head pc=8 transfers -> pc 8 accepted, next cycle if_valid=0, then if_pc=32'h100.
REQ-035 Redirect to 32'hFFFF_FFF8, if_ready=1 -> if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 With IFETCH_MISALIGN_CHECK_EN, redirect to 32'h102 -> fetch_fault=1, if_valid=0; redirect to 32'h200 -> fetch_fault=0, if_pc=32'h200; without macro, 32'h102 -> if_pc=32'h100.
REQ-037 rst asserted with FIFO full and redirect_valid=1 -> next cycle if_valid=0, imem_addr=RESET_PC.
